// File: rtl/nios_security_input_pio.sv
// nios_security_input_pio
// Avalon-MM read-side PIO for the nios_security system. External inputs
// (STOP button, limit/security sensors) are brought into the clk domain by a
// two-flop synchroniser. They can optionally be debounced per bit. Selected
// edges are then latched into a sticky, write-1-to-clear capture register.
// A maskable level interrupt to the Nios II is raised from that register.
//
// Register map (word address):
//   0 : accepted input value (read only)
//   1 : reserved, reads 0
//   2 : irqmask (read/write)
//   3 : edgecapture (read, write-1-to-clear)

module nios_security_input_pio #(
    parameter int WIDTH           = 32,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // Widen a WIDTH-bit register to the 32-bit bus, upper bits zero.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] event_s;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] clear_s;
    logic             wr_s;

    // Two-flop synchroniser; nothing sits between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            // With debounce off, the second synchroniser flop is the
            // accepted value. This gives a two-edge in_port-to-readdata
            // latency.
            assign stable_s = sync2_r;
        end else begin : g_debounce
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] cnt_r;
                logic          bit_r;

                // Accept a changed input only after it has differed from the
                // accepted value for DEBOUNCE_CYCLES consecutive cycles.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_r <= '0;
                        bit_r <= 1'b0;
                    end else if (sync2_r[i] == bit_r) begin
                        cnt_r <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        bit_r <= sync2_r[i];
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end

                assign stable_s[i] = bit_r;
            end
        end
    endgenerate

    // Previous accepted value, for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= '0;
        end else begin
            prev_r <= stable_s;
        end
    end

    // Select which transitions of the accepted value count as events.
    always_comb begin
        event_s = '0;
        case (EDGE_TYPE)
            0:       event_s = stable_s & ~prev_r;
            1:       event_s = ~stable_s & prev_r;
            2:       event_s = stable_s ^ prev_r;
            default: event_s = stable_s & ~prev_r;
        endcase
    end

    // Write qualification and write-1-to-clear mask for the capture register.
    always_comb begin
        wr_s    = chipselect & ~write_n;
        clear_s = '0;
        if (wr_s && (address == ADDR_EDGECAP)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            clear_s = '0;
        end
    end

    // Sticky edge capture: a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= '0;
        end else begin
            edgecap_r <= (edgecap_r & ~clear_s) | event_s;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r <= '0;
        end else if (wr_s && (address == ADDR_IRQMASK)) begin
            irqmask_r <= writedata[WIDTH-1:0];
        end
    end

    // Level interrupt built only from registers, so it cannot glitch on bus
    // activity.
    assign irq = |(edgecap_r & irqmask_r);

    // Zero-wait-state read decode; reads have no side effects.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:     readdata = zext(stable_s);
            ADDR_RESERVED: readdata = 32'd0;
            ADDR_IRQMASK:  readdata = zext(irqmask_r);
            ADDR_EDGECAP:  readdata = zext(edgecap_r);
            default:       readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_security_input_pio.sv
// Directed bench for nios_security_input_pio. Four instances share the bus
// and inputs: rising/no debounce, falling, any-edge, and rising with a
// 4-cycle debounce.

module tb_nios_security_input_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address_s;
    logic        chipselect_s;
    logic        write_n_s;
    logic [31:0] writedata_s;
    logic [31:0] in_port_s;
    logic [31:0] rd_main_s, rd_fall_s, rd_any_s, rd_db_s;
    logic        irq_main_s, irq_fall_s, irq_any_s, irq_db_s;

    int total_cnt;
    int bad_cnt;

    nios_security_input_pio #(.WIDTH(32), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_main (
        .clk(clk), .reset_n(reset_n), .address(address_s), .chipselect(chipselect_s),
        .write_n(write_n_s), .writedata(writedata_s), .in_port(in_port_s),
        .readdata(rd_main_s), .irq(irq_main_s));

    nios_security_input_pio #(.WIDTH(32), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address_s), .chipselect(chipselect_s),
        .write_n(write_n_s), .writedata(writedata_s), .in_port(in_port_s),
        .readdata(rd_fall_s), .irq(irq_fall_s));

    nios_security_input_pio #(.WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address_s), .chipselect(chipselect_s),
        .write_n(write_n_s), .writedata(writedata_s), .in_port(in_port_s),
        .readdata(rd_any_s), .irq(irq_any_s));

    nios_security_input_pio #(.WIDTH(32), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u_db (
        .clk(clk), .reset_n(reset_n), .address(address_s), .chipselect(chipselect_s),
        .write_n(write_n_s), .writedata(writedata_s), .in_port(in_port_s),
        .readdata(rd_db_s), .irq(irq_db_s));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        address_s = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address_s    = a;
        writedata_s  = d;
        chipselect_s = 1'b1;
        write_n_s    = 1'b0;
        tick();
        chipselect_s = 1'b0;
        write_n_s    = 1'b1;
        writedata_s  = 32'd0;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        in_port_s    = 32'd0;
        address_s    = 2'd0;
        chipselect_s = 1'b0;
        write_n_s    = 1'b1;
        writedata_s  = 32'd0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;

        // Reset state
        do_reset();
        rd(2'd0); check_value("rst_data", rd_main_s, 32'd0);
        rd(2'd2); check_value("rst_mask", rd_main_s, 32'd0);
        rd(2'd3); check_value("rst_ec",   rd_main_s, 32'd0);
        check_value("rst_irq", {31'd0, irq_main_s}, 32'd0);

        // Sync latency and rising capture
        in_port_s = 32'h0000_00A5;
        rd(2'd0);
        check_value("data_e0", rd_main_s, 32'd0);
        tick(); check_value("data_e1", rd_main_s, 32'd0);
        tick(); check_value("data_e2", rd_main_s, 32'h0000_00A5);
        rd(2'd3); check_value("ec_e2", rd_main_s, 32'd0);
        tick(); check_value("ec_e3", rd_main_s, 32'h0000_00A5);
        check_value("irq_nomask", {31'd0, irq_main_s}, 32'd0);

        // Interrupt path
        wr(2'd2, 32'h0000_0004);
        check_value("irq_mask", {31'd0, irq_main_s}, 32'd1);
        rd(2'd2); check_value("mask_rd", rd_main_s, 32'h0000_0004);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3); check_value("ec_clr0", rd_main_s, 32'h0000_00A4);
        check_value("irq_still", {31'd0, irq_main_s}, 32'd1);
        wr(2'd3, 32'h0000_0004);
        rd(2'd3); check_value("ec_clr2", rd_main_s, 32'h0000_00A0);
        check_value("irq_off", {31'd0, irq_main_s}, 32'd0);

        // Writes to addr 0/1 ignored, reserved reads 0
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0); check_value("wr0_data", rd_main_s, 32'h0000_00A5);
        rd(2'd1); check_value("rsvd_rd",  rd_main_s, 32'd0);
        rd(2'd2); check_value("wr01_mask", rd_main_s, 32'h0000_0004);
        rd(2'd3); check_value("wr01_ec",  rd_main_s, 32'h0000_00A0);

        // Clear on the same cycle as a new event: set wins
        wr(2'd2, 32'h0000_0100);
        in_port_s = 32'h0000_01A5;
        tick();
        tick();
        wr(2'd3, 32'h0000_0100);
        rd(2'd3); check_value("simul_ec", rd_main_s, 32'h0000_01A0);
        check_value("simul_irq", {31'd0, irq_main_s}, 32'd1);
        wr(2'd3, 32'h0000_0100);
        rd(2'd3); check_value("simul_clr", rd_main_s, 32'h0000_00A0);
        check_value("simul_irq0", {31'd0, irq_main_s}, 32'd0);

        // Falling and any-edge capture
        do_reset();
        in_port_s = 32'h0000_0001;
        repeat (3) tick();
        rd(2'd3);
        check_value("fall_rise_ign", rd_fall_s, 32'd0);
        check_value("any_rise", rd_any_s, 32'h0000_0001);
        wr(2'd3, 32'h0000_0001);
        check_value("any_clr", rd_any_s, 32'd0);
        in_port_s = 32'd0;
        tick();
        tick();
        check_value("fall_pend", rd_fall_s, 32'd0);
        tick();
        check_value("fall_cap", rd_fall_s, 32'h0000_0001);
        check_value("any_fall", rd_any_s, 32'h0000_0001);
        check_value("rise_nofall", rd_main_s, 32'd0);

        // Debounce: 3-cycle glitch rejected
        do_reset();
        in_port_s = 32'h0000_0001;
        repeat (3) tick();
        in_port_s = 32'd0;
        repeat (6) tick();
        rd(2'd0); check_value("db_glitch_data", rd_db_s, 32'd0);
        rd(2'd3); check_value("db_glitch_ec", rd_db_s, 32'd0);
        check_value("nodb_glitch_ec", rd_main_s, 32'h0000_0001);

        // Debounce: 6-cycle pulse accepted after edge 6, captured after edge 7
        rd(2'd0);
        in_port_s = 32'h0000_0001;
        repeat (5) tick();
        check_value("db_e5", rd_db_s, 32'd0);
        tick();
        check_value("db_e6", rd_db_s, 32'h0000_0001);
        rd(2'd3); check_value("db_ec_e6", rd_db_s, 32'd0);
        tick();
        check_value("db_ec_e7", rd_db_s, 32'h0000_0001);

        // Reset in the middle of a debounce with a capture pending
        wr(2'd2, 32'h0000_0001);
        check_value("db_irq", {31'd0, irq_db_s}, 32'd1);
        in_port_s = 32'd0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_value("mid_rst_irq_db", {31'd0, irq_db_s}, 32'd0);
        check_value("mid_rst_irq_main", {31'd0, irq_main_s}, 32'd0);
        rd(2'd0); check_value("mid_rst_data", rd_db_s, 32'd0);
        rd(2'd2); check_value("mid_rst_mask", rd_db_s, 32'd0);
        rd(2'd3); check_value("mid_rst_ec", rd_db_s, 32'd0);
        check_value("mid_rst_ec_main", rd_main_s, 32'd0);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
